id: RTL and testbench

ID -- requirements
Module: id

---
 rtl/id_pkg.sv | 45 ++++
 rtl/id_ctrl_dec.sv | 31 +++
 rtl/id.sv | 58 +++++
 tb/tb_id.sv | 128 ++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode-stage definitions: opcode map, bus widths and packed bundle layouts
// used by the decode stage and its control decoder.
package id_pkg;

  localparam int FS_BUS_W = 16;
  localparam int DS_BUS_W = 28;
  localparam int DATA_W   = 8;
  localparam int PC_W     = 8;
  localparam int INST_W   = 8;
  localparam int OP_W     = 4;
  localparam int REG_W    = 2;
  localparam int CTRL_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV   = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h3;
  localparam logic [OP_W-1:0] OP_AND   = 4'h4;
  localparam logic [OP_W-1:0] OP_OR    = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT   = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL   = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR   = 4'h9;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'hA;
  localparam logic [OP_W-1:0] OP_STORE = 4'hB;
  localparam logic [OP_W-1:0] OP_CMP   = 4'hC;

  typedef struct packed {
    logic we;
    logic mem_rd;
    logic mem_wr;
    logic illegal;
  } ctrl_t;

  // Field order here defines the bit layout seen by the execute stage.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rx;
    logic [REG_W-1:0]  ry;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rx_value;
    logic [DATA_W-1:0] ry_value;
  } ds_bus_t;

endpackage

// File: rtl/id_ctrl_dec.sv
// Combinational opcode-to-control decoder for the decode stage.
// Every opcode maps to exactly one of the legal control patterns.
module id_ctrl_dec
  import id_pkg::*;
(
  input  logic [3:0] op,
  output logic       we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       illegal
);

  always_comb begin
    we      = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_NOP, OP_CMP: ;
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR: we = 1'b1;
      OP_LOAD: begin
        we     = 1'b1;
        mem_rd = 1'b1;
      end
      OP_STORE: mem_wr = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id.sv
// Decode stage: splits the fetch bundle, drives register-file read addresses
// combinationally and registers the decoded bundle for the execute stage.
module id
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fs_to_ds_bus,
  output logic [1:0]  rx,
  output logic [1:0]  ry,
  input  logic [7:0]  rx_value,
  input  logic [7:0]  ry_value,
  output logic [27:0] ds_to_es_bus
);

  logic [PC_W-1:0]   pc_unused;
  logic [INST_W-1:0] inst;
  logic [OP_W-1:0]   op;
  ctrl_t             ctrl;
  ds_bus_t           ds_bus_p0;
  ds_bus_t           ds_bus_p1;

  assign pc_unused = fs_to_ds_bus[15:8];
  assign inst      = fs_to_ds_bus[7:0];
  assign op        = inst[7:4];
  assign rx        = inst[3:2];
  assign ry        = inst[1:0];

  id_ctrl_dec u_ctrl_dec (
    .op      (op),
    .we      (ctrl.we),
    .mem_rd  (ctrl.mem_rd),
    .mem_wr  (ctrl.mem_wr),
    .illegal (ctrl.illegal)
  );

  always_comb begin
    ds_bus_p0          = '0;
    ds_bus_p0.op       = op;
    ds_bus_p0.rx       = rx;
    ds_bus_p0.ry       = ry;
    ds_bus_p0.ctrl     = ctrl;
    ds_bus_p0.rx_value = rx_value;
    ds_bus_p0.ry_value = ry_value;
  end

  // p0 -> p1: decode/execute boundary; reset clears the bundle asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_bus_p1 <= '0;
    end else begin
      ds_bus_p1 <= ds_bus_p0;
    end
  end

  assign ds_to_es_bus = ds_bus_p1;

endmodule

// File: tb/tb_id.sv
// Self-checking bench for the decode stage: directed vectors plus random
// instructions compared against an opcode-table reference model.
module tb_id;

  logic        clk;
  logic        reset;
  logic [15:0] fs_to_ds_bus;
  logic [1:0]  rx;
  logic [1:0]  ry;
  logic [7:0]  rx_value;
  logic [7:0]  ry_value;
  logic [27:0] ds_to_es_bus;

  int n_checks = 0;
  int n_errors = 0;

  id dut (
    .clk          (clk),
    .reset        (reset),
    .fs_to_ds_bus (fs_to_ds_bus),
    .rx           (rx),
    .ry           (ry),
    .rx_value     (rx_value),
    .ry_value     (ry_value),
    .ds_to_es_bus (ds_to_es_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: opcode classes taken straight from the opcode table.
  function automatic logic [27:0] ref_bus(input logic [7:0] inst, input logic [7:0] xv,
                                          input logic [7:0] yv);
    int   opn;
    logic w, rd, wr, ill;
    opn = int'(inst) / 16;
    w   = (opn >= 1 && opn <= 10);
    rd  = (opn == 10);
    wr  = (opn == 11);
    ill = (opn >= 13);
    return {inst, w, rd, wr, ill, xv, yv};
  endfunction

  // Drive at the falling edge, check address outputs, then check the bundle after the rising edge.
  task automatic step(input logic [15:0] fs, input logic [7:0] xv, input logic [7:0] yv,
                      input string tag);
    @(negedge clk);
    fs_to_ds_bus = fs;
    rx_value     = xv;
    ry_value     = yv;
    #1;
    check_eq({tag, "_rx"}, {26'd0, rx}, {26'd0, 2'((fs % 16) / 4)});
    check_eq({tag, "_ry"}, {26'd0, ry}, {26'd0, 2'(fs % 4)});
    @(posedge clk);
    #1;
    check_eq({tag, "_bus"}, ds_to_es_bus, ref_bus(fs[7:0], xv, yv));
  endtask

  initial begin
    reset        = 1'b1;
    fs_to_ds_bus = 16'hABCD;
    rx_value     = 8'h00;
    ry_value     = 8'h00;
    #1;
    check_eq("rst_bus_async", ds_to_es_bus, 28'h0);
    @(posedge clk);
    #1;
    check_eq("rst_bus", ds_to_es_bus, 28'h0);
    check_eq("rst_rx", {26'd0, rx}, 28'd3);
    check_eq("rst_ry", {26'd0, ry}, 28'd1);

    @(negedge clk);
    reset = 1'b0;
    step(16'hABCD, 8'h12, 8'h34, "cmp");
    check_eq("cmp_const", ds_to_es_bus, 28'hCD01234);
    step(16'h5678, 8'h56, 8'h78, "not");
    check_eq("not_const", ds_to_es_bus, 28'h7885678);
    check_eq("not_rx", {26'd0, rx}, 28'd2);
    check_eq("not_ry", {26'd0, ry}, 28'd0);
    step(16'h00A6, 8'h01, 8'h02, "load");
    check_eq("load_const", ds_to_es_bus, 28'hA6C0102);
    step(16'h00B6, 8'h01, 8'h02, "store");
    check_eq("store_const", ds_to_es_bus, 28'hB620102);
    step(16'h00F0, 8'hFF, 8'hFF, "illegal");
    check_eq("illegal_const", ds_to_es_bus, 28'hF01FFFF);

    for (int o = 0; o < 16; o++) begin
      step({8'h3C, 4'(o), 4'(o)}, 8'(o * 17), 8'(255 - o), $sformatf("op%0d", o));
    end

    for (int i = 0; i < 200; i++) begin
      step(16'($urandom), 8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
    end

    // Mid-cycle reset must clear the bundle before the next edge.
    step(16'h12F7, 8'hAA, 8'h55, "pre_mid");
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_clear", ds_to_es_bus, 28'h0);
    fs_to_ds_bus = 16'h0009;
    #1;
    check_eq("mid_rst_rx", {26'd0, rx}, 28'd2);
    check_eq("mid_rst_ry", {26'd0, ry}, 28'd1);
    @(posedge clk);
    #1;
    check_eq("mid_rst_hold", ds_to_es_bus, 28'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_wait", ds_to_es_bus, 28'h0);
    @(posedge clk);
    #1;
    check_eq("post_rst_cap", ds_to_es_bus, ref_bus(8'h09, 8'hAA, 8'h55));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
